status_register: RTL and testbench

- Processor status (P) register for the 6502 core, directly downstream of the ALU.
- Captures the ALU flag outputs (carry, zero, negative, overflow) under a per-flag update mask.
- Executes flag set/clear, BIT-test, pull-from-bus and interrupt-entry updates.
- Feeds the carry back to the ALU carry input, produces the push byte for PHP/BRK/IRQ, and provides the instruction-delayed IRQ mask used by the interrupt sequencer.

---
 rtl/status_register_if.sv | 33 +++
 rtl/status_register.sv | 118 +++++++++++
 tb/tb_status_register.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/status_register_if.sv
// Bundles the flag-update bus between the instruction sequencer/ALU side and the
// 6502 processor status register, plus the flag and interrupt outputs fed back.
interface status_register_if;
    logic [2:0] op;
    logic [3:0] flag_mask;
    logic [2:0] flag_sel;
    logic       flag_carry;
    logic       flag_zero;
    logic       flag_neg;
    logic       flag_overflow;
    logic [7:0] data_in;
    logic       brk_push;
    logic       instr_done;
    logic       irq_line;
    logic [7:0] p_out;
    logic [7:0] push_byte;
    logic       carry_out;
    logic       decimal_out;
    logic       irq_mask_eff;
    logic       irq_take;

    modport master (
        output op, flag_mask, flag_sel, flag_carry, flag_zero, flag_neg,
               flag_overflow, data_in, brk_push, instr_done, irq_line,
        input  p_out, push_byte, carry_out, decimal_out, irq_mask_eff, irq_take
    );

    modport slave (
        input  op, flag_mask, flag_sel, flag_carry, flag_zero, flag_neg,
               flag_overflow, data_in, brk_push, instr_done, irq_line,
        output p_out, push_byte, carry_out, decimal_out, irq_mask_eff, irq_take
    );
endinterface

// File: rtl/status_register.sv
// 6502 processor status (P) register: applies one registered flag update per cycle
// and tracks the instruction-delayed IRQ mask used by the interrupt sequencer.
module status_register #(
    parameter logic [7:0] RESET_P = 8'h24
) (
    input logic         clk,
    input logic         reset,
    status_register_if.slave bus
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_ALU  = 3'd1,
        OP_LOAD = 3'd2,
        OP_SET  = 3'd3,
        OP_CLR  = 3'd4,
        OP_BIT  = 3'd5,
        OP_INT  = 3'd6,
        OP_RSVD = 3'd7
    } op_t;

    op_t  op;
    logic flag_n, flag_v, flag_d, flag_i, flag_z, flag_c;
    logic flag_n_next, flag_v_next, flag_d_next, flag_i_next, flag_z_next, flag_c_next;
    logic irq_mask_q, irq_mask_next;
    logic sel_value;
    logic unused_data_bits;

    assign op               = op_t'(bus.op);
    assign sel_value        = (op == OP_SET);
    assign unused_data_bits = ^bus.data_in[5:4];

    always_comb begin
        flag_n_next = flag_n;
        flag_v_next = flag_v;
        flag_d_next = flag_d;
        flag_i_next = flag_i;
        flag_z_next = flag_z;
        flag_c_next = flag_c;

        case (op)
            OP_ALU: begin
                if (bus.flag_mask[3]) flag_n_next = bus.flag_neg;
                if (bus.flag_mask[2]) flag_v_next = bus.flag_overflow;
                if (bus.flag_mask[1]) flag_z_next = bus.flag_zero;
                if (bus.flag_mask[0]) flag_c_next = bus.flag_carry;
            end
            OP_LOAD: begin
                flag_n_next = bus.data_in[7];
                flag_v_next = bus.data_in[6];
                flag_d_next = bus.data_in[3];
                flag_i_next = bus.data_in[2];
                flag_z_next = bus.data_in[1];
                flag_c_next = bus.data_in[0];
            end
            OP_SET, OP_CLR: begin
                // Indices 4 and 5 name the unstored B and constant bits, so they are ignored
                case (bus.flag_sel)
                    3'd0:    flag_c_next = sel_value;
                    3'd1:    flag_z_next = sel_value;
                    3'd2:    flag_i_next = sel_value;
                    3'd3:    flag_d_next = sel_value;
                    3'd6:    flag_v_next = sel_value;
                    3'd7:    flag_n_next = sel_value;
                    default: ;
                endcase
            end
            OP_BIT: begin
                flag_n_next = bus.data_in[7];
                flag_v_next = bus.data_in[6];
                flag_z_next = bus.flag_zero;
            end
            OP_INT: begin
                flag_i_next = 1'b1;
            end
            default: ;
        endcase
    end

    // The mask samples the pre-edge I so a CLI/SEI/PLP only takes effect one
    // instruction later; interrupt entry masks immediately regardless.
    always_comb begin
        irq_mask_next = irq_mask_q;
        if (op == OP_INT) begin
            irq_mask_next = 1'b1;
        end else if (bus.instr_done) begin
            irq_mask_next = flag_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_n     <= RESET_P[7];
            flag_v     <= RESET_P[6];
            flag_d     <= RESET_P[3];
            flag_i     <= RESET_P[2];
            flag_z     <= RESET_P[1];
            flag_c     <= RESET_P[0];
            irq_mask_q <= 1'b1;
        end else begin
            flag_n     <= flag_n_next;
            flag_v     <= flag_v_next;
            flag_d     <= flag_d_next;
            flag_i     <= flag_i_next;
            flag_z     <= flag_z_next;
            flag_c     <= flag_c_next;
            irq_mask_q <= irq_mask_next;
        end
    end

    assign bus.p_out        = {flag_n, flag_v, 1'b1, 1'b0, flag_d, flag_i, flag_z, flag_c};
    assign bus.push_byte    = {flag_n, flag_v, 1'b1, bus.brk_push, flag_d, flag_i, flag_z, flag_c};
    assign bus.carry_out    = flag_c;
    assign bus.decimal_out  = flag_d;
    assign bus.irq_mask_eff = irq_mask_q;
    assign bus.irq_take     = bus.irq_line & ~irq_mask_q;

endmodule

// File: tb/tb_status_register.sv
// Bench for status_register: directed scenarios followed by random updates, each
// compared against a byte-level model of the P register and IRQ mask.
module tb_status_register;

    logic clk;
    logic reset;
    int   pass_count;
    int   check_count;

    logic [7:0] model_p;
    logic       model_mask;

    status_register_if bus ();

    status_register #(.RESET_P(8'h24)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else $error("[TB] FAIL %s: observed %02h expected %02h", tag, obs, exp);
    endtask

    task automatic check_output(input string tag);
        logic [7:0] exp_push;
        exp_push = (model_p & 8'hEF) | (bus.brk_push ? 8'h10 : 8'h00);
        check_val({tag, ".p_out"}, bus.p_out, model_p);
        check_val({tag, ".push_byte"}, bus.push_byte, exp_push);
        check_val({tag, ".carry_out"}, {7'd0, bus.carry_out}, {7'd0, model_p[0]});
        check_val({tag, ".decimal_out"}, {7'd0, bus.decimal_out}, {7'd0, model_p[3]});
        check_val({tag, ".irq_mask_eff"}, {7'd0, bus.irq_mask_eff}, {7'd0, model_mask});
        check_val({tag, ".irq_take"}, {7'd0, bus.irq_take}, {7'd0, bus.irq_line & ~model_mask});
    endtask

    // Reference: treat P as a byte and apply each update with masks and bit ops
    task automatic model_step();
        logic [7:0] bit_pos;
        logic [3:0] alu_vals;
        logic       old_i;
        old_i    = model_p[2];
        alu_vals = {bus.flag_neg, bus.flag_overflow, bus.flag_zero, bus.flag_carry};
        case (bus.op)
            3'd1: begin
                for (int k = 0; k < 4; k++) begin
                    bit_pos = (k == 0) ? 8'h01 : (k == 1) ? 8'h02 : (k == 2) ? 8'h40 : 8'h80;
                    if (bus.flag_mask[k])
                        model_p = alu_vals[k] ? (model_p | bit_pos) : (model_p & ~bit_pos);
                end
            end
            3'd2: model_p = (bus.data_in & 8'hCF) | 8'h20;
            3'd3: if (bus.flag_sel != 3'd4 && bus.flag_sel != 3'd5)
                      model_p = model_p | (8'h01 << bus.flag_sel);
            3'd4: if (bus.flag_sel != 3'd4 && bus.flag_sel != 3'd5)
                      model_p = model_p & ~(8'h01 << bus.flag_sel);
            3'd5: model_p = (model_p & 8'h3D) | (bus.data_in & 8'hC0) | (bus.flag_zero ? 8'h02 : 8'h00);
            3'd6: model_p = model_p | 8'h04;
            default: ;
        endcase
        if (bus.op == 3'd6) model_mask = 1'b1;
        else if (bus.instr_done) model_mask = old_i;
    endtask

    task automatic apply_stimulus(input logic [2:0] op, input logic [3:0] mask,
                                  input logic [2:0] sel, input logic [3:0] nvzc,
                                  input logic [7:0] data, input logic brk,
                                  input logic done, input logic irq);
        bus.op            = op;
        bus.flag_mask     = mask;
        bus.flag_sel      = sel;
        bus.flag_neg      = nvzc[3];
        bus.flag_overflow = nvzc[2];
        bus.flag_zero     = nvzc[1];
        bus.flag_carry    = nvzc[0];
        bus.data_in       = data;
        bus.brk_push      = brk;
        bus.instr_done    = done;
        bus.irq_line      = irq;
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_output(tag);
    endtask

    initial begin
        pass_count  = 0;
        check_count = 0;
        reset       = 1'b1;
        apply_stimulus(3'd0, 4'h0, 3'd0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        #12;
        reset      = 1'b0;
        model_p    = 8'h24;
        model_mask = 1'b1;
        check_output("por");

        // Async reset mid-cycle with a LOAD pending and an IRQ requested
        apply_stimulus(3'd2, 4'h0, 3'd0, 4'h0, 8'hFF, 1'b0, 1'b1, 1'b1);
        step("load_ff_pre");
        #2;
        reset = 1'b1;
        #1;
        model_p    = 8'h24;
        model_mask = 1'b1;
        check_output("async_reset");
        @(posedge clk);
        #1;
        check_output("reset_held");
        apply_stimulus(3'd0, 4'h0, 3'd0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step("hold");
        check_val("hold_const", bus.p_out, 8'h24);

        apply_stimulus(3'd1, 4'b1011, 3'd0, 4'b1101, 8'h00, 1'b0, 1'b0, 1'b0);
        step("alu_1011");
        check_val("alu_1011_const", bus.p_out, 8'hA5);
        apply_stimulus(3'd1, 4'b0100, 3'd0, 4'b0100, 8'h00, 1'b0, 1'b0, 1'b0);
        step("alu_0100");
        check_val("alu_0100_const", bus.p_out, 8'hE5);

        apply_stimulus(3'd2, 4'h0, 3'd0, 4'h0, 8'hFF, 1'b1, 1'b0, 1'b0);
        step("load_ff");
        check_val("push_brk1_const", bus.push_byte, 8'hFF);
        bus.brk_push = 1'b0;
        #1;
        check_output("push_brk0");
        check_val("push_brk0_const", bus.push_byte, 8'hEF);
        apply_stimulus(3'd2, 4'h0, 3'd0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        step("load_00");
        check_val("load_00_const", bus.p_out, 8'h20);

        apply_stimulus(3'd3, 4'h0, 3'd0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        step("sec");
        apply_stimulus(3'd3, 4'h0, 3'd3, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        step("sed");
        check_val("sed_const", bus.p_out, 8'h29);
        apply_stimulus(3'd4, 4'h0, 3'd0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        step("clc");
        check_val("clc_const", bus.p_out, 8'h28);
        apply_stimulus(3'd3, 4'h0, 3'd5, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        step("set_sel5");
        check_val("set_sel5_const", bus.p_out, 8'h28);

        // CLI takes effect on irq_take only after the following instruction completes
        apply_stimulus(3'd3, 4'h0, 3'd2, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
        step("sei");
        apply_stimulus(3'd4, 4'h0, 3'd2, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1);
        step("cli_done");
        check_val("cli_take_const", {7'd0, bus.irq_take}, 8'h00);
        apply_stimulus(3'd0, 4'h0, 3'd0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1);
        step("next_done");
        check_val("next_take_const", {7'd0, bus.irq_take}, 8'h01);
        apply_stimulus(3'd6, 4'h0, 3'd0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1);
        step("int_done");
        check_val("int_take_const", {7'd0, bus.irq_take}, 8'h00);

        apply_stimulus(3'd2, 4'h0, 3'd0, 4'h0, 8'h25, 1'b0, 1'b0, 1'b0);
        step("load_25");
        apply_stimulus(3'd5, 4'h0, 3'd0, 4'b0010, 8'hC0, 1'b0, 1'b0, 1'b0);
        step("bit_c0");
        check_val("bit_c0_const", bus.p_out, 8'hE7);

        for (int i = 0; i < 300; i++) begin
            apply_stimulus(3'($urandom_range(0, 7)), 4'($urandom), 3'($urandom),
                           4'($urandom), 8'($urandom), 1'($urandom),
                           ($urandom_range(0, 2) == 0), 1'($urandom));
            step("random");
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
